// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register state encoding and the NOP bubble word.
package cpu_types_pkg;

  // Encodings match the entry count, so the state register doubles as occ.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_NOP_MAX_W = 256;

  // All-zero bundle: every WEN/DWE/HALT-style control field deasserted.
  localparam logic [PIPE_NOP_MAX_W-1:0] PIPE_NOP = '0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for pipeline stall/bubble statistics.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional skid entry,
// synchronous flush to a NOP bubble and saturating stall/bubble counters.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(PIPE_NOP);

  pipe_state_t       state;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] skidData;
  logic              inFire;
  logic              outFire;

  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = mainData;
  assign occ       = state;

  // With a skid entry, in_ready depends only on the state flop, breaking the
  // combinational ready chain between stages.
  generate
    if (SKID != 0) begin : gSkid
      assign in_ready = (state != FULL);
    end else begin : gNoSkid
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= EMPTY;
      mainData <= NOP;
      skidData <= NOP;
    end else if (flush) begin
      state    <= EMPTY;
      mainData <= NOP;
      skidData <= NOP;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            mainData <= in_data;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            mainData <= in_data;
          end else if (outFire) begin
            state <= EMPTY;
          end else if (inFire && (SKID != 0)) begin
            skidData <= in_data;
            state    <= FULL;
          end
        end
        FULL: begin
          if (outFire) begin
            mainData <= skidData;
            state    <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) uStallCnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (out_valid & ~out_ready),
    .cnt  (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) uBubbleCnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (~out_valid & out_ready),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance and a no-skid,
// 4-bit-counter instance share clock and reset.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nRST;

  logic        sFlush, sInValid, sInReady, sOutValid, sOutReady;
  logic [31:0] sInData, sOutData;
  logic [1:0]  sOcc;
  logic [15:0] sStall, sBubble;

  logic        nFlush, nInValid, nInReady, nOutValid, nOutReady;
  logic [31:0] nInData, nOutData;
  logic [1:0]  nOcc;
  logic [3:0]  nStall, nBubble;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dutSkid (
    .CLK(clk), .nRST(nRST), .flush(sFlush),
    .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData),
    .occ(sOcc), .stall_cnt(sStall), .bubble_cnt(sBubble)
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(4)) dutNoSkid (
    .CLK(clk), .nRST(nRST), .flush(nFlush),
    .in_valid(nInValid), .in_ready(nInReady), .in_data(nInData),
    .out_valid(nOutValid), .out_ready(nOutReady), .out_data(nOutData),
    .occ(nOcc), .stall_cnt(nStall), .bubble_cnt(nBubble)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream must hold in_valid/in_data until accepted (flush releases it);
  // the no-skid stage must never report two entries.
  logic        sPend = 1'b0;
  logic [31:0] sHeld = '0;
  always @(negedge clk) begin
    if (nRST) begin
      if (sPend) begin
        check("upValidHeld", sInValid, 1'b1);
        check("upDataHeld", sInData, sHeld);
      end
      check("noSkidOccMax", nOcc == 2'd2, 1'b0);
      sPend = sInValid & ~sInReady & ~sFlush;
      sHeld = sInData;
    end else begin
      sPend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    sFlush = 1'b1; sInValid = 1'b1; sInData = 32'hDEADBEEF; sOutReady = 1'b0;
    nFlush = 1'b1; nInValid = 1'b1; nInData = 32'hDEADBEEF; nOutReady = 1'b0;
    tick();
    tick();
    check("rstValid", sOutValid, 1'b0);
    check("rstData", sOutData, 32'h0);
    check("rstOcc", sOcc, 2'd0);
    check("rstStall", sStall, 16'd0);
    check("rstBubble", sBubble, 16'd0);
    check("rstNValid", nOutValid, 1'b0);
    check("rstNData", nOutData, 32'h0);
    check("rstNBubble", nBubble, 4'd0);

    nRST = 1'b1;
    sFlush = 1'b0; sInValid = 1'b0;
    nFlush = 1'b0; nInValid = 1'b0;
    #1;
    check("rstInReady", sInReady, 1'b1);
    check("rstNInReady", nInReady, 1'b1);

    // Streaming with the sink always ready
    sOutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sInValid = 1'b1;
      sInData  = 32'(i);
      tick();
      check("streamData", sOutData, 64'(i));
      check("streamValid", sOutValid, 1'b1);
    end
    sInValid = 1'b0;
    tick();
    check("streamDrained", sOutValid, 1'b0);
    check("streamBubble", sBubble, 16'd1);

    // Back-pressure fills main then skid
    sOutReady = 1'b0;
    sInValid = 1'b1; sInData = 32'hA;
    tick();
    sInData = 32'hB;
    tick();
    check("bpOcc", sOcc, 2'd2);
    check("bpInReady", sInReady, 1'b0);
    check("bpStall1", sStall, 16'd1);
    check("bpHeadA", sOutData, 32'hA);
    sInValid = 1'b0;
    tick();
    check("bpStall2", sStall, 16'd2);
    check("bpHoldA", sOutData, 32'hA);
    sOutReady = 1'b1;
    #1;
    check("bpReadyReg", sInReady, 1'b0);
    tick();
    check("bpHeadB", sOutData, 32'hB);
    check("bpInReadyBack", sInReady, 1'b1);
    check("bpOccB", sOcc, 2'd1);
    tick();
    check("bpEmpty", sOutValid, 1'b0);
    check("bpOcc0", sOcc, 2'd0);

    // Flush while FULL, with a competing input C
    sOutReady = 1'b0;
    sInValid = 1'b1; sInData = 32'h11;
    tick();
    sInData = 32'h22;
    tick();
    check("flFullOcc", sOcc, 2'd2);
    check("flStall3", sStall, 16'd3);
    sInData = 32'hC; sFlush = 1'b1;
    tick();
    check("flOcc", sOcc, 2'd0);
    check("flValid", sOutValid, 1'b0);
    check("flData", sOutData, 32'h0);
    check("flStall4", sStall, 16'd4);
    check("flInReady", sInReady, 1'b1);
    sFlush = 1'b0; sInValid = 1'b0;
    tick();
    check("flNoC", sOutValid, 1'b0);
    check("flStallKept", sStall, 16'd4);

    // Flush in BUSY drops a same-cycle accepted input
    sOutReady = 1'b1;
    sInValid = 1'b1; sInData = 32'h55;
    tick();
    check("fbData55", sOutData, 32'h55);
    check("fbBubble2", sBubble, 16'd2);
    sInData = 32'h66; sFlush = 1'b1;
    tick();
    check("fbValid", sOutValid, 1'b0);
    check("fbData", sOutData, 32'h0);
    check("fbBubbleKept", sBubble, 16'd2);
    sFlush = 1'b0; sInValid = 1'b0;
    tick();
    check("fbNo66", sOutValid, 1'b0);
    check("fbBubble3", sBubble, 16'd3);

    // No-skid instance: combinational ready, back-to-back replace
    nOutReady = 1'b0;
    nInValid = 1'b1; nInData = 32'h77;
    #1;
    check("nsReadyEmpty", nInReady, 1'b1);
    tick();
    check("nsData77", nOutData, 32'h77);
    check("nsReadyStall", nInReady, 1'b0);
    nInData = 32'h88;
    tick();
    check("nsHold77", nOutData, 32'h77);
    check("nsStall1", nStall, 4'd1);
    check("nsOcc1", nOcc, 2'd1);
    nOutReady = 1'b1;
    #1;
    check("nsReadyComb", nInReady, 1'b1);
    tick();
    check("nsData88", nOutData, 32'h88);
    check("nsValid88", nOutValid, 1'b1);
    nInData = 32'h99;
    tick();
    check("nsData99", nOutData, 32'h99);
    nInValid = 1'b0;
    tick();
    check("nsDrained", nOutValid, 1'b0);
    check("nsBubble0", nBubble, 4'd0);

    // 4-bit bubble counter saturates at 15
    for (int i = 0; i < 14; i++) tick();
    check("satBubble14", nBubble, 4'd14);
    for (int i = 0; i < 6; i++) tick();
    check("satBubble15", nBubble, 4'd15);
    check("satStallKept", nStall, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
